rs_c1_err_locate: RTL and testbench

RS_C1_ERR_LOCATE -- requirements
Module: rs_c1_err_locate

---
 rtl/rs_c1_err_locate_pkg.sv | 36 +++
 rtl/gf256_inv.sv | 52 +++++
 rtl/gf256_mult.sv | 12 +
 rtl/rs_c1_err_locate.sv | 158 +++++++++++++++
 tb/tb_rs_c1_err_locate.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_c1_err_locate_pkg.sv
// Shared GF(2^8) definitions for the C1 single-error locator: field polynomial,
// generator, status codes, FSM states and a combinational multiply.
package rs_c1_err_locate_pkg;

  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam logic [7:0] ALPHA   = 8'h02;

  typedef enum logic [1:0] {
    ST_NO_ERR = 2'b00,
    ST_SINGLE = 2'b01,
    ST_UNCORR = 2'b10
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_INV,
    S_MUL,
    S_SEARCH,
    S_DONE
  } fsm_e;

  // Shift-and-add multiply; the multiplicand is reduced by the field polynomial as it shifts.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = '0;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? GF_POLY[7:0] : 8'h00);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf256_inv.sv
// Sequential GF(2^8) inverter computing x^254 by seven square-and-accumulate steps.
// o_ready drops on i_start and rises when o_y holds the new inverse.
module gf256_inv
  import rs_c1_err_locate_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_x,
  output logic       o_ready,
  output logic [7:0] o_y
);

  logic       r_run;
  logic [2:0] r_cnt;
  logic [7:0] r_sq;
  logic [7:0] r_acc;
  logic [7:0] w_sq2;
  logic [7:0] w_acc_next;

  // After step i: r_sq = x^(2^i), r_acc = x^(2^(i+1)-2); step 7 gives x^254 = x^-1.
  assign w_sq2      = gf_mul(r_sq, r_sq);
  assign w_acc_next = gf_mul(r_acc, w_sq2);

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_run   <= 1'b0;
      r_cnt   <= '0;
      r_sq    <= '0;
      r_acc   <= 8'h01;
      o_ready <= 1'b0;
      o_y     <= '0;
    end else if (i_start) begin
      r_run   <= 1'b1;
      r_cnt   <= '0;
      r_sq    <= i_x;
      r_acc   <= 8'h01;
      o_ready <= 1'b0;
    end else if (r_run) begin
      r_sq  <= w_sq2;
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + 3'd1;
      if (r_cnt == 3'd6) begin
        r_run   <= 1'b0;
        o_ready <= 1'b1;
        o_y     <= w_acc_next;
      end
    end
  end

endmodule

// File: rtl/gf256_mult.sv
// Combinational GF(2^8) multiplier over the 0x11D field.
module gf256_mult
  import rs_c1_err_locate_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_p
);

  assign o_p = gf_mul(i_a, i_b);

endmodule

// File: rtl/rs_c1_err_locate.sv
// C1 single-error locator: checks syndrome consistency, forms X = S1/S0 and
// searches alpha^k == X over k = 0..N-1, reporting position and magnitude.
module rs_c1_err_locate
  import rs_c1_err_locate_pkg::*;
#(
  parameter int N = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_s0,
  input  logic [7:0] i_s1,
  input  logic [7:0] i_s2,
  input  logic [7:0] i_s3,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_status,
  output logic [7:0] o_err_pos,
  output logic [7:0] o_err_val
);

  localparam logic [7:0] K_LAST = 8'(N - 1);

  fsm_e       r_state;
  logic [7:0] r_s0, r_s1, r_s2, r_s3;
  logic       r_inv_start;
  logic       r_ready_prev;
  logic [7:0] r_inv_y;
  logic [7:0] r_x;
  logic [7:0] r_p;
  logic [7:0] r_k;

  logic [7:0] w_s1s1, w_s0s2, w_s2s2, w_s1s3;
  logic [7:0] w_x;
  logic [7:0] w_p_next;
  logic       w_inv_ready;
  logic [7:0] w_inv_y;
  logic       w_ready_rise;

  // A single error gives S(i+1) = X*S(i), so S1^2 = S0*S2 and S2^2 = S1*S3.
  gf256_mult u_mul_s1s1 (.i_a(r_s1), .i_b(r_s1),    .o_p(w_s1s1));
  gf256_mult u_mul_s0s2 (.i_a(r_s0), .i_b(r_s2),    .o_p(w_s0s2));
  gf256_mult u_mul_s2s2 (.i_a(r_s2), .i_b(r_s2),    .o_p(w_s2s2));
  gf256_mult u_mul_s1s3 (.i_a(r_s1), .i_b(r_s3),    .o_p(w_s1s3));
  gf256_mult u_mul_x    (.i_a(r_s1), .i_b(r_inv_y), .o_p(w_x));
  gf256_mult u_mul_p    (.i_a(r_p),  .i_b(ALPHA),   .o_p(w_p_next));

  gf256_inv u_inv (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (r_inv_start),
    .i_x     (r_s0),
    .o_ready (w_inv_ready),
    .o_y     (w_inv_y)
  );

  // Only a rise seen after our own start pulse counts; o_ready falls on that pulse.
  assign w_ready_rise = w_inv_ready & ~r_ready_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_s0         <= '0;
      r_s1         <= '0;
      r_s2         <= '0;
      r_s3         <= '0;
      r_inv_start  <= 1'b0;
      r_ready_prev <= 1'b0;
      r_inv_y      <= '0;
      r_x          <= '0;
      r_p          <= 8'h01;
      r_k          <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_status     <= ST_NO_ERR;
      o_err_pos    <= '0;
      o_err_val    <= '0;
    end else begin
      r_ready_prev <= w_inv_ready;
      r_inv_start  <= 1'b0;
      o_done       <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_s0    <= i_s0;
            r_s1    <= i_s1;
            r_s2    <= i_s2;
            r_s3    <= i_s3;
            o_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if ({r_s0, r_s1, r_s2, r_s3} == 32'h0) begin
            o_status  <= ST_NO_ERR;
            o_err_pos <= '0;
            o_err_val <= '0;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            r_state   <= S_DONE;
          end else if ((r_s0 == 8'h00) || (w_s1s1 != w_s0s2) || (w_s2s2 != w_s1s3)) begin
            o_status  <= ST_UNCORR;
            o_err_pos <= '0;
            o_err_val <= '0;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_inv_start <= 1'b1;
            r_state     <= S_INV;
          end
        end

        S_INV: begin
          if (!r_inv_start && w_ready_rise) begin
            r_inv_y <= w_inv_y;
            r_state <= S_MUL;
          end
        end

        S_MUL: begin
          r_x     <= w_x;
          r_p     <= 8'h01;
          r_k     <= '0;
          r_state <= S_SEARCH;
        end

        S_SEARCH: begin
          if (r_p == r_x) begin
            o_status  <= ST_SINGLE;
            o_err_pos <= r_k;
            o_err_val <= r_s0;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_k == K_LAST) begin
            o_status  <= ST_UNCORR;
            o_err_pos <= '0;
            o_err_val <= '0;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_p <= w_p_next;
            r_k <= r_k + 8'd1;
          end
        end

        S_DONE: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_c1_err_locate.sv
// Bench for rs_c1_err_locate: directed and random syndromes checked against a
// GF(2^8) reference decoder, plus reset-abort and busy-start scenarios.
module tb_rs_c1_err_locate;

  localparam int N      = 32;
  localparam int T_INV  = 8;
  localparam int LIMIT  = N + T_INV + 20;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic [7:0] i_s0, i_s1, i_s2, i_s3;
  logic       o_busy, o_done;
  logic [1:0] o_status;
  logic [7:0] o_err_pos, o_err_val;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rs_c1_err_locate #(.N(N)) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_s0      (i_s0),
    .i_s1      (i_s1),
    .i_s2      (i_s2),
    .i_s3      (i_s3),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_status  (o_status),
    .o_err_pos (o_err_pos),
    .o_err_val (o_err_val)
  );

  // Reference field arithmetic: carry-less product then polynomial reduction.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011D << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] m_pow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < (e % 255); i++) r = m_mul(r, 8'h02);
    return r;
  endfunction

  // Syndromes of a single error of magnitude e at position k.
  task automatic m_synd(input logic [7:0] e, input int k,
                        output logic [7:0] s0, output logic [7:0] s1,
                        output logic [7:0] s2, output logic [7:0] s3);
    s0 = e;
    s1 = m_mul(e, m_pow(k));
    s2 = m_mul(e, m_pow(2 * k));
    s3 = m_mul(e, m_pow(3 * k));
  endtask

  // Expected decode: solve S0*b = S1 by exhaustive search, then find alpha^k = b.
  task automatic m_decode(input logic [7:0] s0, input logic [7:0] s1,
                          input logic [7:0] s2, input logic [7:0] s3,
                          output logic [1:0] st, output logic [7:0] pos,
                          output logic [7:0] val, output int lat);
    logic [7:0] b;
    bit found;
    st = 2'b10; pos = 8'h00; val = 8'h00; lat = 2;
    b = 8'h00; found = 1'b0;
    if (s0 == 0 && s1 == 0 && s2 == 0 && s3 == 0) begin
      st = 2'b00;
    end else if (s0 != 0 && m_mul(s1, s1) == m_mul(s0, s2) && m_mul(s2, s2) == m_mul(s1, s3)) begin
      for (int c = 0; c < 256; c++) if (m_mul(s0, 8'(c)) == s1) b = 8'(c);
      for (int k = 0; k < N; k++) begin
        if (!found && m_pow(k) == b) begin
          found = 1'b1;
          pos   = 8'(k);
        end
      end
      if (found) begin
        st  = 2'b01;
        val = s0;
        lat = 5 + T_INV + int'(pos);
      end else begin
        lat = N + T_INV + 4;
      end
    end
  endtask

  // Pulses start with the given syndromes and counts cycles to o_done (-1 on timeout).
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, output int lat, output logic busy1);
    @(negedge clk);
    i_s0 = a; i_s1 = b; i_s2 = c; i_s3 = d;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_s0 = 8'($urandom); i_s1 = 8'($urandom); i_s2 = 8'($urandom); i_s3 = 8'($urandom);
    busy1 = o_busy;
    lat = 1;
    while (o_done !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    if (o_done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_start = 1'b0;
    i_s0 = 8'h00; i_s1 = 8'h00; i_s2 = 8'h00; i_s3 = 8'h00;
    repeat (3) @(negedge clk);
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", o_done); end
    n_vec++; if (o_status !== 2'b00) begin n_err++; $display("FAIL reset_status: got %b want 00", o_status); end
    n_vec++; if (o_err_pos !== 8'h00) begin n_err++; $display("FAIL reset_pos: got %h want 00", o_err_pos); end
    n_vec++; if (o_err_val !== 8'h00) begin n_err++; $display("FAIL reset_val: got %h want 00", o_err_val); end
    i_rst = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [7:0] s[4];
    logic [1:0] st;
    logic [7:0] pos;
    logic [7:0] val;
    int         lat;
  } dcase_t;

  task automatic test_directed;
    dcase_t tc[7];
    logic [7:0] a, b, c, d;
    int lat;
    logic busy1;
    tc[0] = '{"zero",     '{8'h00, 8'h00, 8'h00, 8'h00}, 2'b00, 8'h00, 8'h00, 2};
    tc[1] = '{"e5_k3",    '{8'h05, 8'h28, 8'h5D, 8'hD2}, 2'b01, 8'h03, 8'h05, 5 + T_INV + 3};
    tc[2] = '{"e1_k0",    '{8'h01, 8'h01, 8'h01, 8'h01}, 2'b01, 8'h00, 8'h01, 5 + T_INV};
    m_synd(8'h01, 31, a, b, c, d);
    tc[3] = '{"e1_k31",   '{a, b, c, d},                 2'b01, 8'h1F, 8'h01, N + T_INV + 4};
    tc[4] = '{"s0_zero",  '{8'h00, 8'h01, 8'h00, 8'h00}, 2'b10, 8'h00, 8'h00, 2};
    tc[5] = '{"inconsis", '{8'h01, 8'h02, 8'h03, 8'h04}, 2'b10, 8'h00, 8'h00, 2};
    m_synd(8'h01, 40, a, b, c, d);
    tc[6] = '{"e1_k40",   '{a, b, c, d},                 2'b10, 8'h00, 8'h00, N + T_INV + 4};
    for (int i = 0; i < 7; i++) begin
      apply(tc[i].s[0], tc[i].s[1], tc[i].s[2], tc[i].s[3], lat, busy1);
      n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL %s busy: got %b want 1", tc[i].name, busy1); end
      n_vec++; if (lat != tc[i].lat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", tc[i].name, lat, tc[i].lat); end
      n_vec++; if (o_status !== tc[i].st) begin n_err++; $display("FAIL %s status: got %b want %b", tc[i].name, o_status, tc[i].st); end
      n_vec++; if (o_err_pos !== tc[i].pos) begin n_err++; $display("FAIL %s pos: got %h want %h", tc[i].name, o_err_pos, tc[i].pos); end
      n_vec++; if (o_err_val !== tc[i].val) begin n_err++; $display("FAIL %s val: got %h want %h", tc[i].name, o_err_val, tc[i].val); end
    end
  endtask

  task automatic test_random;
    logic [7:0] a, b, c, d, e, pos, val;
    logic [1:0] st;
    int lat, elat, kind, k;
    logic busy1;
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 9));
      e = 8'($urandom_range(1, 255));
      if (kind < 5) begin
        k = int'($urandom_range(0, N - 1));
        m_synd(e, k, a, b, c, d);
      end else if (kind < 7) begin
        k = int'($urandom_range(N, 254));
        m_synd(e, k, a, b, c, d);
      end else if (kind < 9) begin
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      end else begin
        a = 8'h00; b = 8'h00; c = 8'h00; d = 8'($urandom_range(1, 255));
      end
      m_decode(a, b, c, d, st, pos, val, elat);
      apply(a, b, c, d, lat, busy1);
      n_vec++; if (lat != elat) begin n_err++; $display("FAIL rand%0d latency: got %0d want %0d", i, lat, elat); end
      n_vec++; if (o_status !== st) begin n_err++; $display("FAIL rand%0d status: got %b want %b", i, o_status, st); end
      n_vec++; if (o_err_pos !== pos) begin n_err++; $display("FAIL rand%0d pos: got %h want %h", i, o_err_pos, pos); end
      n_vec++; if (o_err_val !== val) begin n_err++; $display("FAIL rand%0d val: got %h want %h", i, o_err_val, val); end
    end
  endtask

  // Starts the k=31 case, resets after abort_at cycles, then decodes e=5 at k=3.
  task automatic test_reset_abort(input string name, input int abort_at);
    logic [7:0] a, b, c, d;
    int lat;
    logic busy1;
    bit saw_done;
    m_synd(8'h01, 31, a, b, c, d);
    saw_done = 1'b0;
    @(negedge clk);
    i_s0 = a; i_s1 = b; i_s2 = c; i_s3 = d;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int i = 1; i < abort_at; i++) begin
      if (o_done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    for (int i = 0; i < N + T_INV + 8; i++) begin
      if (o_done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    n_vec++; if (saw_done) begin n_err++; $display("FAIL %s aborted_done: got 1 want 0", name); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL %s post_reset_busy: got %b want 0", name, o_busy); end
    n_vec++; if (o_status !== 2'b00) begin n_err++; $display("FAIL %s post_reset_status: got %b want 00", name, o_status); end
    apply(8'h05, 8'h28, 8'h5D, 8'hD2, lat, busy1);
    n_vec++; if (lat != 5 + T_INV + 3) begin n_err++; $display("FAIL %s restart_latency: got %0d want %0d", name, lat, 5 + T_INV + 3); end
    n_vec++; if (o_status !== 2'b01) begin n_err++; $display("FAIL %s restart_status: got %b want 01", name, o_status); end
    n_vec++; if (o_err_pos !== 8'h03) begin n_err++; $display("FAIL %s restart_pos: got %h want 03", name, o_err_pos); end
    n_vec++; if (o_err_val !== 8'h05) begin n_err++; $display("FAIL %s restart_val: got %h want 05", name, o_err_val); end
  endtask

  task automatic test_start_while_busy;
    int lat;
    @(negedge clk);
    i_s0 = 8'h05; i_s1 = 8'h28; i_s2 = 8'h5D; i_s3 = 8'hD2;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    lat = 1;
    repeat (3) begin @(negedge clk); lat++; end
    i_s0 = 8'h01; i_s1 = 8'h01; i_s2 = 8'h01; i_s3 = 8'h01;
    i_start = 1'b1;
    @(negedge clk);
    lat++;
    i_start = 1'b0;
    while (o_done !== 1'b1 && lat < LIMIT) begin @(negedge clk); lat++; end
    if (o_done !== 1'b1) lat = -1;
    n_vec++; if (lat != 5 + T_INV + 3) begin n_err++; $display("FAIL busy_start latency: got %0d want %0d", lat, 5 + T_INV + 3); end
    n_vec++; if (o_status !== 2'b01) begin n_err++; $display("FAIL busy_start status: got %b want 01", o_status); end
    n_vec++; if (o_err_pos !== 8'h03) begin n_err++; $display("FAIL busy_start pos: got %h want 03", o_err_pos); end
    n_vec++; if (o_err_val !== 8'h05) begin n_err++; $display("FAIL busy_start val: got %h want 05", o_err_val); end
  endtask

  // Results must hold after o_done, and a start right after DONE must be taken.
  task automatic test_back_to_back;
    int lat;
    logic busy1;
    apply(8'h01, 8'h01, 8'h01, 8'h01, lat, busy1);
    repeat (3) @(negedge clk);
    n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL hold_done: got %b want 0", o_done); end
    n_vec++; if (o_status !== 2'b01) begin n_err++; $display("FAIL hold_status: got %b want 01", o_status); end
    n_vec++; if (o_err_val !== 8'h01) begin n_err++; $display("FAIL hold_val: got %h want 01", o_err_val); end
    apply(8'h05, 8'h28, 8'h5D, 8'hD2, lat, busy1);
    apply(8'h00, 8'h00, 8'h00, 8'h00, lat, busy1);
    n_vec++; if (lat != 2) begin n_err++; $display("FAIL b2b_latency: got %0d want 2", lat); end
    n_vec++; if (o_status !== 2'b00) begin n_err++; $display("FAIL b2b_status: got %b want 00", o_status); end
    n_vec++; if (o_err_pos !== 8'h00) begin n_err++; $display("FAIL b2b_pos: got %h want 00", o_err_pos); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_reset_abort("abort_search", 16);
    test_reset_abort("abort_inv", 5);
    test_start_while_busy;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
